// File: rtl/mc_control.sv
// mc_control: multicycle control sequencer issuing ALU and datapath controls per state.
// Define MC_OVFL_TRAP_EN to trap signed overflow of add/sub/addi instead of writing back.
module mc_control (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       ovfl,
    input  logic       mem_ack,
    output logic [3:0] aluc,
    output logic [1:0] alua_sel,
    output logic [2:0] alub_sel,
    output logic [1:0] pc_sel,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic [1:0] regdst,
    output logic [1:0] wb_sel,
    output logic       illegal,
    output logic       exc,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t cur, nxt;
    logic [3:0] r_code, i_code;
    logic r_ok, r_shift, r_jr, i_ok, i_zext;
    logic is_r, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, legal, taken;

    always_comb begin
        r_code  = 4'b0000;
        r_ok    = 1'b1;
        r_shift = 1'b0;
        r_jr    = 1'b0;
        case (func)
            6'h20: r_code = 4'b0010;
            6'h21: r_code = 4'b0000;
            6'h22: r_code = 4'b0011;
            6'h23: r_code = 4'b0001;
            6'h24: r_code = 4'b0100;
            6'h25: r_code = 4'b0101;
            6'h26: r_code = 4'b0110;
            6'h27: r_code = 4'b0111;
            6'h2a: r_code = 4'b1011;
            6'h2b: r_code = 4'b1010;
            6'h00: begin r_code = 4'b1110; r_shift = 1'b1; end
            6'h02: begin r_code = 4'b1101; r_shift = 1'b1; end
            6'h03: begin r_code = 4'b1100; r_shift = 1'b1; end
            6'h08: r_jr = 1'b1;
            default: r_ok = 1'b0;
        endcase
    end

    always_comb begin
        i_code = 4'b0000;
        i_ok   = 1'b1;
        i_zext = 1'b0;
        case (op)
            6'h08: i_code = 4'b0010;
            6'h09: i_code = 4'b0000;
            6'h0a: i_code = 4'b1011;
            6'h0b: i_code = 4'b1010;
            6'h0c: begin i_code = 4'b0100; i_zext = 1'b1; end
            6'h0d: begin i_code = 4'b0101; i_zext = 1'b1; end
            6'h0e: begin i_code = 4'b0110; i_zext = 1'b1; end
            6'h0f: begin i_code = 4'b1000; i_zext = 1'b1; end
            default: i_ok = 1'b0;
        endcase
    end

    assign is_r   = (op == 6'h00);
    assign is_j   = (op == 6'h02);
    assign is_jal = (op == 6'h03);
    assign is_beq = (op == 6'h04);
    assign is_bne = (op == 6'h05);
    assign is_lw  = (op == 6'h23);
    assign is_sw  = (op == 6'h2b);
    assign legal  = (is_r & r_ok) | i_ok | is_lw | is_sw | is_beq | is_bne | is_j | is_jal;
    assign taken  = (is_beq & zero) | (is_bne & ~zero);
    assign state  = cur;

`ifdef MC_OVFL_TRAP_EN
    logic trap_op;
    assign trap_op = (is_r & ((func == 6'h20) | (func == 6'h22))) | (op == 6'h08);
`else
    logic unused_ovfl;
    assign unused_ovfl = ovfl;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cur <= S_IF;
        else         cur <= nxt;
    end

    always_comb begin
        nxt      = cur;
        aluc     = 4'b0000;
        alua_sel = 2'd0;
        alub_sel = 3'd0;
        pc_sel   = 2'd0;
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        reg_we   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        iord     = 1'b0;
        regdst   = 2'd0;
        wb_sel   = 2'd0;
        illegal  = 1'b0;
        exc      = 1'b0;
        case (cur)
            S_IF: begin
                mem_req  = 1'b1;
                alub_sel = 3'd1;
                // an ack seen while reset is held must not latch an instruction
                if (mem_ack && resetn) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                    nxt   = S_ID;
                end
            end
            S_ID: begin
                alub_sel = 3'd4;
                nxt      = S_EXE;
                if (is_j || is_jal) begin
                    pc_we  = 1'b1;
                    pc_sel = 2'd2;
                    reg_we = is_jal;
                    regdst = is_jal ? 2'd2 : 2'd0;
                    wb_sel = is_jal ? 2'd2 : 2'd0;
                    nxt    = S_IF;
                end else if (is_r && r_jr) begin
                    pc_we  = 1'b1;
                    pc_sel = 2'd3;
                    nxt    = S_IF;
                end else if (!legal) begin
                    illegal = 1'b1;
                    nxt     = S_IF;
                end
            end
            S_EXE: begin
                alua_sel = 2'd1;
                if (is_beq || is_bne) begin
                    aluc   = 4'b0001;
                    pc_we  = taken;
                    pc_sel = taken ? 2'd1 : 2'd0;
                    nxt    = S_IF;
                end else if (is_lw || is_sw) begin
                    alub_sel = 3'd2;
                    nxt      = S_MEM;
                end else if (is_r) begin
                    aluc     = r_code;
                    alua_sel = r_shift ? 2'd2 : 2'd1;
                    nxt      = S_WB;
                end else begin
                    aluc     = i_code;
                    alub_sel = i_zext ? 3'd3 : 3'd2;
                    nxt      = S_WB;
                end
`ifdef MC_OVFL_TRAP_EN
                if (trap_op && ovfl) begin
                    exc = 1'b1;
                    nxt = S_IF;
                end
`endif
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = is_sw;
                if (mem_ack) nxt = is_lw ? S_WB : S_IF;
            end
            S_WB: begin
                reg_we = 1'b1;
                regdst = is_r ? 2'd1 : 2'd0;
                wb_sel = is_lw ? 2'd1 : 2'd0;
                nxt    = S_IF;
            end
            default: nxt = S_IF;
        endcase
    end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized instruction streams checked cycle by cycle against an instruction-level model.
module tb_mc_control;
    logic clk = 1'b0, resetn = 1'b0;
    logic [5:0] op = '0, func = '0;
    logic zero = 1'b0, ovfl = 1'b0, mem_ack = 1'b0;
    logic [3:0] aluc;
    logic [1:0] alua_sel, pc_sel, regdst, wb_sel;
    logic [2:0] alub_sel, state;
    logic pc_we, ir_we, reg_we, mem_req, mem_we, iord, illegal, exc;

    mc_control dut (
        .clk(clk), .resetn(resetn), .op(op), .func(func), .zero(zero), .ovfl(ovfl),
        .mem_ack(mem_ack), .aluc(aluc), .alua_sel(alua_sel), .alub_sel(alub_sel),
        .pc_sel(pc_sel), .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_req(mem_req),
        .mem_we(mem_we), .iord(iord), .regdst(regdst), .wb_sel(wb_sel), .illegal(illegal),
        .exc(exc), .state(state)
    );

    always #5 clk = ~clk;

`ifdef MC_OVFL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] aluc;
        logic [1:0] a;
        logic [2:0] b;
        logic [1:0] pcs;
        logic pcw, irw, rw, mr, mw, io;
        logic [1:0] rd, wb;
        logic il, ex;
    } outs_t;

    typedef struct {
        logic [5:0] o, f;
        logic ack, z, ov;
        outs_t e;
    } cyc_t;

    localparam int K_ILL = 0, K_R = 1, K_SH = 2, K_JR = 3, K_IA = 4, K_IZ = 5;
    localparam int K_LW = 6, K_SW = 7, K_BEQ = 8, K_BNE = 9, K_J = 10, K_JAL = 11;

    cyc_t sched[$];
    int vectors = 0, errors = 0;
    outs_t rst_e;

    function automatic outs_t act();
        return {state, aluc, alua_sel, alub_sel, pc_sel, pc_we, ir_we, reg_we,
                mem_req, mem_we, iord, regdst, wb_sel, illegal, exc};
    endfunction

    function automatic int kind_of(logic [5:0] o, logic [5:0] f);
        if (o == 6'h00) begin
            case (f)
                6'h00, 6'h02, 6'h03: return K_SH;
                6'h08: return K_JR;
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: return K_R;
                default: return K_ILL;
            endcase
        end
        case (o)
            6'h02: return K_J;
            6'h03: return K_JAL;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h08, 6'h09, 6'h0a, 6'h0b: return K_IA;
            6'h0c, 6'h0d, 6'h0e, 6'h0f: return K_IZ;
            6'h23: return K_LW;
            6'h2b: return K_SW;
            default: return K_ILL;
        endcase
    endfunction

    // ALU operation by mnemonic: add/addi, addu/addiu, sub, subu, and, or, xor, nor, slt, sltu, shifts, lui
    function automatic logic [3:0] code_of(logic [5:0] o, logic [5:0] f);
        logic [5:0] key;
        key = (o == 6'h00) ? f : o;
        if (o == 6'h00) begin
            case (key)
                6'h20: return 4'b0010; 6'h21: return 4'b0000;
                6'h22: return 4'b0011; 6'h23: return 4'b0001;
                6'h24: return 4'b0100; 6'h25: return 4'b0101;
                6'h26: return 4'b0110; 6'h27: return 4'b0111;
                6'h2a: return 4'b1011; 6'h2b: return 4'b1010;
                6'h00: return 4'b1110; 6'h02: return 4'b1101;
                default: return 4'b1100;
            endcase
        end
        case (key)
            6'h08: return 4'b0010; 6'h09: return 4'b0000;
            6'h0a: return 4'b1011; 6'h0b: return 4'b1010;
            6'h0c: return 4'b0100; 6'h0d: return 4'b0101;
            6'h0e: return 4'b0110; default: return 4'b1000;
        endcase
    endfunction

    function automatic cyc_t blank(logic [5:0] o, logic [5:0] f, logic [2:0] s);
        cyc_t c;
        c.o = o; c.f = f;
        c.ack = 1'($urandom); c.z = 1'($urandom); c.ov = 1'($urandom);
        c.e = '0;
        c.e.st = s;
        return c;
    endfunction

    // Expected per-cycle behaviour of one whole instruction given memory waits and flags
    task automatic plan(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw,
                        input bit z, input bit ov);
        int k;
        bit tk;
        cyc_t c;
        k = kind_of(o, f);
        for (int i = 0; i <= fw; i++) begin
            c = blank(o, f, 3'd0);
            c.ack = (i == fw);
            c.e.mr = 1'b1; c.e.b = 3'd1;
            c.e.irw = c.ack; c.e.pcw = c.ack;
            sched.push_back(c);
        end
        c = blank(o, f, 3'd1);
        c.e.b = 3'd4;
        if (k == K_J || k == K_JAL) begin c.e.pcw = 1'b1; c.e.pcs = 2'd2; end
        if (k == K_JAL) begin c.e.rw = 1'b1; c.e.rd = 2'd2; c.e.wb = 2'd2; end
        if (k == K_JR) begin c.e.pcw = 1'b1; c.e.pcs = 2'd3; end
        if (k == K_ILL) c.e.il = 1'b1;
        sched.push_back(c);
        if (k == K_J || k == K_JAL || k == K_JR || k == K_ILL) return;
        c = blank(o, f, 3'd2);
        c.e.a = 2'd1;
        if (k == K_BEQ || k == K_BNE) begin
            c.z = z;
            tk = (k == K_BEQ) ? z : !z;
            c.e.aluc = 4'b0001;
            c.e.pcw = tk;
            c.e.pcs = tk ? 2'd1 : 2'd0;
            sched.push_back(c);
            return;
        end
        if (k == K_LW || k == K_SW) c.e.b = 3'd2;
        if (k == K_R || k == K_SH) begin
            c.e.aluc = code_of(o, f);
            c.e.a = (k == K_SH) ? 2'd2 : 2'd1;
        end
        if (k == K_IA || k == K_IZ) begin
            c.e.aluc = code_of(o, f);
            c.e.b = (k == K_IZ) ? 3'd3 : 3'd2;
        end
        if ((o == 6'h00 && (f == 6'h20 || f == 6'h22)) || o == 6'h08) begin
            c.ov = ov;
            if (TRAP && ov) begin
                c.e.ex = 1'b1;
                sched.push_back(c);
                return;
            end
        end
        sched.push_back(c);
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= mw; i++) begin
                c = blank(o, f, 3'd3);
                c.ack = (i == mw);
                c.e.mr = 1'b1; c.e.io = 1'b1; c.e.mw = (k == K_SW);
                sched.push_back(c);
            end
            if (k == K_SW) return;
        end
        c = blank(o, f, 3'd4);
        c.e.rw = 1'b1;
        c.e.rd = (k == K_R || k == K_SH) ? 2'd1 : 2'd0;
        c.e.wb = (k == K_LW) ? 2'd1 : 2'd0;
        sched.push_back(c);
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(negedge clk);
        vectors++;
        if (act() !== rst_e) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", act(), rst_e);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        plan(6'h23, 6'h00, 0, 4, 0, 0);
        for (int i = 0; i < 5; i++) begin
            op = sched[i].o; func = sched[i].f;
            mem_ack = sched[i].ack; zero = sched[i].z; ovfl = sched[i].ov;
            @(negedge clk);
            vectors++;
            if (act() !== sched[i].e) begin
                errors++;
                $display("FAIL reset_lw_pre cyc %0d: got %h want %h", i, act(), sched[i].e);
            end
            @(posedge clk); #1;
        end
        sched.delete();
        resetn = 1'b0;
        mem_ack = 1'b1;
        #1;
        vectors++;
        if (act() !== rst_e) begin
            errors++;
            $display("FAIL reset_mid_mem: got %h want %h", act(), rst_e);
        end
        @(posedge clk); #1;
        vectors++;
        if (act() !== rst_e) begin
            errors++;
            $display("FAIL reset_after_edge: got %h want %h", act(), rst_e);
        end
        resetn = 1'b1;
        plan(6'h00, 6'h21, 0, 0, 0, 0);
        foreach (sched[i]) begin
            op = sched[i].o; func = sched[i].f;
            mem_ack = sched[i].ack; zero = sched[i].z; ovfl = sched[i].ov;
            @(negedge clk);
            vectors++;
            if (act() !== sched[i].e) begin
                errors++;
                $display("FAIL reset_first_fetch cyc %0d: got %h want %h", i, act(), sched[i].e);
            end
            @(posedge clk); #1;
        end
        sched.delete();
    endtask

    task automatic test_directed();
        plan(6'h00, 6'h21, 2, 0, 0, 0);
        plan(6'h04, 6'h00, 0, 0, 1, 0);
        plan(6'h04, 6'h00, 1, 0, 0, 0);
        plan(6'h05, 6'h00, 0, 0, 0, 0);
        plan(6'h05, 6'h00, 0, 0, 1, 0);
        plan(6'h2b, 6'h00, 0, 2, 0, 0);
        plan(6'h23, 6'h00, 1, 1, 0, 0);
        plan(6'h03, 6'h00, 0, 0, 0, 0);
        plan(6'h02, 6'h00, 0, 0, 0, 0);
        plan(6'h00, 6'h08, 0, 0, 0, 0);
        plan(6'h3f, 6'h00, 0, 0, 0, 0);
        plan(6'h00, 6'h01, 0, 0, 0, 0);
        plan(6'h00, 6'h03, 0, 0, 0, 0);
        plan(6'h0f, 6'h00, 0, 0, 0, 0);
        plan(6'h0a, 6'h00, 0, 0, 0, 0);
        foreach (sched[i]) begin
            op = sched[i].o; func = sched[i].f;
            mem_ack = sched[i].ack; zero = sched[i].z; ovfl = sched[i].ov;
            @(negedge clk);
            vectors++;
            if (act() !== sched[i].e) begin
                errors++;
                $display("FAIL directed cyc %0d op %h fn %h: got %h want %h",
                         i, sched[i].o, sched[i].f, act(), sched[i].e);
            end
            @(posedge clk); #1;
        end
        sched.delete();
    endtask

    task automatic test_ovfl();
        plan(6'h00, 6'h20, 0, 0, 0, 1);
        plan(6'h00, 6'h22, 0, 0, 0, 1);
        plan(6'h08, 6'h00, 0, 0, 0, 1);
        plan(6'h00, 6'h20, 0, 0, 0, 0);
        plan(6'h00, 6'h21, 0, 0, 0, 1);
        foreach (sched[i]) begin
            op = sched[i].o; func = sched[i].f;
            mem_ack = sched[i].ack; zero = sched[i].z; ovfl = sched[i].ov;
            @(negedge clk);
            vectors++;
            if (act() !== sched[i].e) begin
                errors++;
                $display("FAIL ovfl cyc %0d op %h fn %h: got %h want %h",
                         i, sched[i].o, sched[i].f, act(), sched[i].e);
            end
            @(posedge clk); #1;
        end
        sched.delete();
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [17] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                                 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b};
        logic [5:0] fns [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h08};
        logic [5:0] o, f;
        for (int n = 0; n < 300; n++) begin
            o = ($urandom_range(9) == 0) ? 6'($urandom) : ops[$urandom_range(16)];
            f = ($urandom_range(9) == 0) ? 6'($urandom) : fns[$urandom_range(13)];
            plan(o, f, $urandom_range(3), $urandom_range(3), 1'($urandom), 1'($urandom));
        end
        foreach (sched[i]) begin
            op = sched[i].o; func = sched[i].f;
            mem_ack = sched[i].ack; zero = sched[i].z; ovfl = sched[i].ov;
            @(negedge clk);
            vectors++;
            if (act() !== sched[i].e) begin
                errors++;
                $display("FAIL random cyc %0d op %h fn %h: got %h want %h",
                         i, sched[i].o, sched[i].f, act(), sched[i].e);
            end
            @(posedge clk); #1;
        end
        sched.delete();
    endtask

    initial begin
        rst_e = '0;
        rst_e.mr = 1'b1;
        rst_e.b = 3'd1;
        test_reset();
        test_directed();
        test_ovfl();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mc_control.md
# mc_control

Multicycle control sequencer that drives the datapath ALU. It decodes the latched instruction, steps through fetch/decode/execute/memory/writeback states, and issues the 4-bit `aluc` operation codes and datapath selects each cycle. It handshakes with a single shared instruction/data memory port and reacts to the ALU `zero` and `ovfl` flags.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `resetn` in 1: asynchronous, active-low reset.
- `op` in 6: IR[31:26].
- `func` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, combinational from the current cycle.
- `ovfl` in 1: ALU signed-overflow flag, combinational from the current cycle.
- `mem_ack` in 1: memory completes the access this cycle.
- `aluc` out 4: ALU operation code.
- `alua_sel` out 2: ALU A source. 0 = PC, 1 = rs, 2 = shamt.
- `alub_sel` out 3: ALU B source. 0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = zero-extended imm, 4 = sign-extended imm<<2.
- `pc_sel` out 2: next-PC source. 0 = ALU result, 1 = ALUOut register, 2 = jump target, 3 = rs.
- `pc_we`, `ir_we`, `reg_we`, `mem_req`, `mem_we`, `iord` out 1 each. `iord` selects the address: 0 = PC, 1 = ALUOut.
- `regdst` out 2: destination register. 0 = rt, 1 = rd, 2 = $31.
- `wb_sel` out 2: writeback data. 0 = ALUOut, 1 = MDR, 2 = PC.
- `illegal` out 1: one-cycle pulse on an undecodable instruction.
- `exc` out 1: one-cycle overflow-trap pulse.
- `state` out 3: current state, for debug.

## Operation
- aluc codes:
  - add 0010, addu 0000, sub 0011, subu 0001
  - and 0100, or 0101, xor 0110, nor 0111
  - lui 1000, slt 1011, sltu 1010
  - sra 1100, srl 1101, sll 1110
- Decoded instructions:
  - R-type (`op` = 0): add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr.
  - I-type: addi, addiu, slti, sltiu, andi, ori, xori, lui, lw, sw, beq, bne.
  - J-type: j, jal.
  - Anything else is illegal.
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4.
- IF:
  - `mem_req`=1, `iord`=0, ALU computes PC+4 (alua 0, alub 1, aluc 0000).
  - On `mem_ack`: `ir_we`=`pc_we`=1 with `pc_sel` 0, then go to ID. Otherwise stay in IF.
- ID:
  - ALU computes PC + (sext imm<<2) into ALUOut (alua 0, alub 4, aluc 0000).
  - j: `pc_we`, `pc_sel` 2, then IF.
  - jal: same as j, plus `reg_we`, `regdst` 2, `wb_sel` 2 (writes the already-incremented PC), then IF.
  - jr: `pc_we`, `pc_sel` 3, then IF.
  - illegal: `illegal`=1, then IF.
  - All others go to EXE.
- EXE:
  - R-ALU ops: alua 1 (2 for shifts), alub 0, then WB.
  - I-arith: alua 1; alub 3 for andi/ori/xori/lui, 2 otherwise; then WB.
  - lw/sw: aluc 0000, alua 1, alub 2, then MEM.
  - beq/bne: aluc 0001, alua 1, alub 0. If (beq & `zero`) | (bne & ~`zero`): `pc_we`, `pc_sel` 1. Go to IF in either case.
- MEM:
  - `mem_req`=1, `iord`=1, `mem_we`=1 for sw.
  - Hold in MEM until `mem_ack`; then lw goes to WB, sw goes to IF.
- WB:
  - `reg_we`=1, then IF.
  - lw: `regdst` 0, `wb_sel` 1. R-type: `regdst` 1, `wb_sel` 0. I-arith: `regdst` 0, `wb_sel` 0.

## Timing
- Outputs are combinational from `state` and `op`/`func`.
- `pc_we`/`ir_we` in IF and the MEM exit depend on `mem_ack` in the same cycle (Mealy). Branch `pc_we` depends on `zero` in the same cycle.
- Any unlisted output is 0 in its state.
- Handshake:
  - `mem_req`, `iord`, and `mem_we` stay stable until `mem_ack` is sampled high.
  - Zero-wait ack is allowed, so a fetch can take 1 cycle.
  - `mem_ack` outside IF/MEM is ignored.
- Latency with zero-wait memory:
  - R/I-arith: 4 cycles. lw: 5. sw: 4. branch: 3. j/jal/jr: 2. illegal: 2.
- Reset:
  - `resetn` low forces state IF immediately, mid-access included. Any pending access is abandoned.
  - Reset-state outputs: `mem_req`=1, `alub_sel`=1; all other outputs 0, including `aluc`=0000 and `state`=0.
  - The first fetch begins on the first edge after `resetn` rises.
- `illegal` and `exc` never assert in the same cycle.

## Configuration
- `MC_OVFL_TRAP_EN`:
  - Defined: in EXE for add/sub/addi, `ovfl`=1 suppresses WB. The block pulses `exc` for that cycle and goes to IF, so no register write occurs.
  - Undefined: `ovfl` is ignored, `exc` is tied 0, and the result is written back.

## Test plan
- Reset mid-MEM of lw, release, `mem_ack`=1 → `state` 0, `mem_req`=1; next edge shows `ir_we`=`pc_we`=1.
- addu (op 0, func 0x21), ack on 3rd IF cycle → IF held 3 cycles, then ID, EXE `aluc`=0000, WB `reg_we`=1 `regdst`=1; 6 cycles total.
- beq with `zero`=1 → EXE `aluc`=0001, `pc_we`=1, `pc_sel`=1. With `zero`=0 → `pc_we`=0. Both return to IF.
- sw (op 0x2B), ack delayed 2 cycles → MEM holds `mem_we`=1 `iord`=1 for 3 cycles, then IF, `reg_we` never 1.
- jal (op 3) → ID asserts `pc_we`, `pc_sel`=2, `reg_we`, `regdst`=2, `wb_sel`=2; next state IF.
- add with `ovfl`=1 in EXE → with `MC_OVFL_TRAP_EN`: `exc` pulses 1 cycle and no `reg_we`. Without: WB `reg_we`=1. Separately, op 0x3F → `illegal` pulses in ID.
